controle_rodadas: RTL
=====================

Name: controle_rodadas

Overview:
- Moore control unit that sequences the round-based memory game datapath.
- Datapath pieces it drives: address counter E, round/limit counter L, play register R, and comparator status.
- Starts a game on `iniciar`. Each round N replays plays 0..N-1 against memory, advances rounds until the final one, and ends in hit, miss or timeout.
- Sits between the top-level game circuit and its datapath. Exposes `pronto`/`acertou`/`errou`/`timeout` and a debug state code for the hex display.

Parameters:
- TIMEOUT_CYCLES, 5000: clock cycles allowed in ESPERA before a timeout (5 s at 1 kHz). Minimum 2.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- iniciar  in  1  start/restart request, level-sampled
- jogada  in  1  single-cycle pulse from datapath: a play was detected
- igual  in  1  played value equals memory word at address E
- enderecoIgualLimite  in  1  E == L
- fimL  in  1  L at last round
- zeraE  out  1  clear address counter
- contaE  out  1  increment address counter
- zeraL  out  1  clear round counter
- contaL  out  1  increment round counter
- zeraR  out  1  clear play register
- registraR  out  1  load play register
- pronto  out  1  game finished
- acertou  out  1  game won
- errou  out  1  game lost (miss or timeout)
- timeout  out  1  loss caused by timeout
- db_estado  out  4  current state code

Behaviour:
- Asynchronous active-low reset: state := INICIAL, timer := 0, asynchronously at any time, including mid-round or mid-timeout. Every output is 0 while reset is low and in INICIAL (`db_estado` = 0x0).
- All outputs are a pure decode of the state register (Moore). Every `zera*`/`conta*`/`registraR` is high for exactly one cycle per visit.
- States (code): transitions, asserted outputs
  - INICIAL (0x0): `iniciar` -> PREPARA; else stay. No outputs.
  - PREPARA (0x1): -> NOVA_RODADA. Asserts `zeraE`, `zeraL`, `zeraR`.
  - NOVA_RODADA (0x2): -> ESPERA. Asserts `zeraE`, `zeraR`.
  - ESPERA (0x3):
    - `jogada` -> REGISTRA.
    - Else if timer == TIMEOUT_CYCLES-1 -> FIM_TIMEOUT.
    - Else stay.
  - REGISTRA (0x4): -> COMPARA. Asserts `registraR`.
  - COMPARA (0x5):
    - `!igual` -> FIM_ERRO.
    - Else if `enderecoIgualLimite` && `fimL` -> FIM_ACERTO.
    - Else if `enderecoIgualLimite` -> PROXIMA_RODADA.
    - Else -> PROXIMO.
  - PROXIMO (0x6): -> ESPERA. Asserts `contaE`.
  - PROXIMA_RODADA (0x7): -> NOVA_RODADA. Asserts `contaL`.
  - FIM_ACERTO (0xA): asserts `pronto`, `acertou`.
  - FIM_ERRO (0xE): asserts `pronto`, `errou`.
  - FIM_TIMEOUT (0xD): asserts `pronto`, `errou`, `timeout`.
  - In all three FIM states: `iniciar` -> PREPARA; else stay.
  - Unused codes -> INICIAL.
- `iniciar` is ignored in states 0x1–0x7. Holding `iniciar` high in a FIM state restarts exactly once per game; the game proceeds normally afterwards.
- `jogada` outside ESPERA is ignored and is not queued.
- Timer, width $clog2(TIMEOUT_CYCLES):
  - Increments each cycle in ESPERA; held at 0 in every other state.
  - So each play gets a fresh TIMEOUT_CYCLES window.
  - On the same cycle as timer == TIMEOUT_CYCLES-1, `jogada` wins (no timeout).
- Latency:
  - `iniciar` sampled -> PREPARA next edge -> ESPERA 2 cycles later.
  - `jogada` -> compare decision 2 cycles later.
  - From the first round: a correct play on the final address of round N reaches ESPERA of round N+1 in 5 cycles.

Optional Feature:
- Macro TIMEOUT_EN.
- Defined: timer and FIM_TIMEOUT behave as above.
- Undefined:
  - Timer is not synthesized.
  - ESPERA waits for `jogada` indefinitely.
  - FIM_TIMEOUT is unreachable.
  - `timeout` is tied to 0.
  - Code 0xD decodes as unused (-> INICIAL).

Test Plan:
- Reset then start: `reset`=0 for 10 cycles then 1; pulse `iniciar` 1 cycle -> `db_estado` 0x1, 0x2, 0x3 on successive edges. One-cycle `zeraE`/`zeraL`/`zeraR` in PREPARA; `zeraE`/`zeraR` in NOVA_RODADA.
- Round progression: in round 1, `jogada` with `igual`=1, `enderecoIgualLimite`=1, `fimL`=0 -> states 0x4, 0x5, 0x7, 0x2, 0x3. `contaL` high exactly 1 cycle; `contaE` never high.
- Mid-round play: `igual`=1, `enderecoIgualLimite`=0 -> 0x4, 0x5, 0x6, 0x3, with `contaE` 1 cycle. Then `igual`=1, `enderecoIgualLimite`=1, `fimL`=1 -> FIM_ACERTO (0xA) with `pronto`=1, `acertou`=1, `errou`=0, held until `iniciar`.
- Miss: `jogada` with `igual`=0 -> 0xE, `pronto`=1, `errou`=1, `acertou`=0. A later `iniciar` pulse -> 0x1 and all status outputs drop to 0.
- Timeout (TIMEOUT_EN, TIMEOUT_CYCLES=8):
  - No `jogada` -> FIM_TIMEOUT exactly 8 cycles after entering ESPERA; `timeout`=1, `errou`=1.
  - Rerun with `jogada` on the 8th cycle -> REGISTRA, no timeout.
  - Without the macro: 10000 idle cycles -> still 0x3.
- Async reset mid-game: drive `reset` low between clock edges while in 0x6 -> `db_estado`=0x0 and all outputs 0 immediately. After release, `jogada` pulses are ignored until `iniciar`.

Source files
------------

// File: rtl/controle_rodadas.sv
// controle_rodadas: Moore control unit sequencing the round-based memory game.
// Optional macro TIMEOUT_EN enables the ESPERA timer and the FIM_TIMEOUT state.
module controle_rodadas #(
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada,
   input  logic       igual,
   input  logic       enderecoIgualLimite,
   input  logic       fimL,
   output logic       zeraE,
   output logic       contaE,
   output logic       zeraL,
   output logic       contaL,
   output logic       zeraR,
   output logic       registraR,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic       timeout,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      INICIAL        = 4'h0,
      PREPARA        = 4'h1,
      NOVA_RODADA    = 4'h2,
      ESPERA         = 4'h3,
      REGISTRA       = 4'h4,
      COMPARA        = 4'h5,
      PROXIMO        = 4'h6,
      PROXIMA_RODADA = 4'h7,
      FIM_ACERTO     = 4'hA,
      FIM_TIMEOUT    = 4'hD,
      FIM_ERRO       = 4'hE
   } t_estado;

   // Output bit order:
   // {zeraE, contaE, zeraL, contaL, zeraR, registraR,
   //  pronto, acertou, errou, timeout}
   t_estado    r_estado;
   t_estado    w_proximo;
   logic [9:0] r_saida;
   logic       w_expirou;

   if (TIMEOUT_CYCLES < 2) begin : g_param_invalido
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   // Output decode of a state; used on the next state so outputs are registered
   function automatic logic [9:0] f_saida(input t_estado e);
      logic [9:0] s;
      s = '0;
      unique case (e)
         PREPARA:        s = 10'b1010100000;
         NOVA_RODADA:    s = 10'b1000100000;
         REGISTRA:       s = 10'b0000010000;
         PROXIMO:        s = 10'b0100000000;
         PROXIMA_RODADA: s = 10'b0001000000;
         FIM_ACERTO:     s = 10'b0000001100;
         FIM_ERRO:       s = 10'b0000001010;
`ifdef TIMEOUT_EN
         FIM_TIMEOUT:    s = 10'b0000001011;
`endif
         default:        s = '0;
      endcase
      return s;
   endfunction

`ifdef TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   logic [TW-1:0] r_timer;

   assign w_expirou = (r_timer == TW'(TIMEOUT_CYCLES - 1));

   // Count cycles spent waiting in ESPERA; zero whenever not staying there
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_timer <= '0;
      end else if (r_estado == ESPERA && w_proximo == ESPERA) begin
         r_timer <= r_timer + TW'(1);
      end else begin
         r_timer <= '0;
      end
   end
`else
   assign w_expirou = 1'b0;
`endif

   // Next-state rules; jogada beats an expiring timer in ESPERA
   always_comb begin
      w_proximo = r_estado;
      unique case (r_estado)
         INICIAL: begin
            if (iniciar) w_proximo = PREPARA;
         end
         PREPARA:        w_proximo = NOVA_RODADA;
         NOVA_RODADA:    w_proximo = ESPERA;
         ESPERA: begin
`ifdef TIMEOUT_EN
            if (jogada)         w_proximo = REGISTRA;
            else if (w_expirou) w_proximo = FIM_TIMEOUT;
`else
            if (jogada)         w_proximo = REGISTRA;
            else if (w_expirou) w_proximo = INICIAL;
`endif
         end
         REGISTRA:       w_proximo = COMPARA;
         COMPARA: begin
            if (!igual)
               w_proximo = FIM_ERRO;
            else if (enderecoIgualLimite && fimL)
               w_proximo = FIM_ACERTO;
            else if (enderecoIgualLimite)
               w_proximo = PROXIMA_RODADA;
            else
               w_proximo = PROXIMO;
         end
         PROXIMO:        w_proximo = ESPERA;
         PROXIMA_RODADA: w_proximo = NOVA_RODADA;
         FIM_ACERTO,
         FIM_ERRO: begin
            if (iniciar) w_proximo = PREPARA;
         end
`ifdef TIMEOUT_EN
         FIM_TIMEOUT: begin
            if (iniciar) w_proximo = PREPARA;
         end
`endif
         default:        w_proximo = INICIAL;
      endcase
   end

   // State register with outputs registered alongside it
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_estado <= INICIAL;
         r_saida  <= '0;
      end else begin
         r_estado <= w_proximo;
         r_saida  <= f_saida(w_proximo);
      end
   end

   assign zeraE     = r_saida[9];
   assign contaE    = r_saida[8];
   assign zeraL     = r_saida[7];
   assign contaL    = r_saida[6];
   assign zeraR     = r_saida[5];
   assign registraR = r_saida[4];
   assign pronto    = r_saida[3];
   assign acertou   = r_saida[2];
   assign errou     = r_saida[1];
`ifdef TIMEOUT_EN
   assign timeout   = r_saida[0];
`else
   assign timeout   = 1'b0;
`endif
   assign db_estado = r_estado;

endmodule
